// File: rtl/ex_div.sv
// ex_div: iterative 32-cycle restoring divider for the EX stage, signed/unsigned,
// with divide-by-zero shortcut, pipeline annul and {remainder, quotient} result.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stallreq
);
  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [2*WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 negq_q, negq_d, negr_q, negr_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH:0]     step;
  logic [WIDTH-1:0]     quo, rmd, abs1, abs2;
  assign abs1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
  // Trial subtract of the divisor from the upper half; keep it only when it does not borrow.
  assign diff = {1'b0, rem_q[2*WIDTH-1:WIDTH]} - {1'b0, dvs_q};
  assign step = diff[WIDTH] ? {rem_q[2*WIDTH-1:0], 1'b0} : {diff[WIDTH-1:0], rem_q[WIDTH-1:0], 1'b1};
  assign quo  = step[WIDTH-1:0];
  assign rmd  = step[2*WIDTH:WIDTH+1];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start && !annul) begin
        if (opdata2 == '0) state_d = BYZERO;
        else begin
          state_d = ON;
          cnt_d   = '0;
          rem_d   = {{WIDTH{1'b0}}, abs1, 1'b0};
          dvs_d   = abs2;
          negq_d  = signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          negr_d  = signed_div && opdata1[WIDTH-1];
        end
      end
      BYZERO: begin
        state_d = annul ? IDLE : END;
        res_d   = annul ? res_q : '0;
      end
      ON: if (annul) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        rem_d = step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = END;
          cnt_d   = '0;
          res_d   = {(negr_q ? -rmd : rmd), (negq_q ? -quo : quo)};
        end
      end
      END: if (annul || !start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end
  assign result   = res_q;
  assign ready    = state_q == END;
  assign stallreq = state_q == BYZERO || state_q == ON || (state_q == IDLE && start && !annul);
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed divides; stimulus queues expected {result, ready cycle},
// a negedge monitor pops and checks on each rising ready.
module tb_ex_div;
  logic        clk = 0, rst = 0, start = 0, signed_div = 0, annul = 0;
  logic [31:0] opdata1 = 0, opdata2 = 0;
  logic [63:0] result;
  logic        ready, stallreq;
  typedef struct {logic [63:0] res; int at;} exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int   cyc = 0, n_cmp = 0, n_bad = 0, st;
  logic rdy_d = 0;

  ex_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
    .result(result), .ready(ready), .stallreq(stallreq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready && !rdy_d) begin
      if (sb.size() == 0) chk("spurious_ready", {63'd0, ready}, 64'd0);
      else begin
        e_mon = sb.pop_front();
        chk("result", result, e_mon.res);
        chk("ready_cycle", cyc, e_mon.at);
      end
    end
    rdy_d = ready;
  end

  task automatic push_exp(input logic [63:0] r, input int lat);
    exp_t x;
    x.res = r;
    x.at  = cyc + lat;
    sb.push_back(x);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] r, input int lat, input bit push);
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = s; start = 1; annul = 0;
    if (push) push_exp(r, lat);
  endtask

  // Holds start until ready, scrambling operands meanwhile; returns stallreq-high cycle count.
  task automatic finish_div(output int stall);
    #1 stall = int'(stallreq);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready) begin
        chk("end_stall", {63'd0, stallreq}, 64'd0);
        start = 0;
        @(negedge clk);
        chk("ready_drop", {63'd0, ready}, 64'd0);
        return;
      end
      stall += int'(stallreq);
      opdata1 = $urandom;
      opdata2 = $urandom;
    end
    chk("ready_timeout", {63'd0, ready}, 64'd1);
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] r);
    int unused;
    issue(a, b, s, r, 33, 1);
    finish_div(unused);
  endtask

  initial begin
    #12;
    chk("rst_result", result, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_stall", {63'd0, stallreq}, 64'd0);
    @(negedge clk) rst = 1;
    issue(32'd100, 32'd7, 0, 64'h00000002_0000000E, 33, 1);
    finish_div(st);
    chk("stall_cycles", st, 64'd33);
    do_div(32'hFFFFFFF9, 32'h00000002, 1, 64'hFFFFFFFF_FFFFFFFD);
    do_div(32'h00000007, 32'hFFFFFFFE, 1, 64'h00000001_FFFFFFFD);
    do_div(32'hFFFFFFF8, 32'hFFFFFFFD, 1, 64'hFFFFFFFE_00000002);
    do_div(32'h80000000, 32'hFFFFFFFF, 1, 64'h00000000_80000000);
    do_div(32'd5, 32'd9, 0, 64'h00000005_00000000);
    issue(32'd123, 32'd0, 0, 64'd0, 2, 1);
    finish_div(st);
    chk("byzero_stall", st, 64'd2);
    do_div(32'hFFFFFFFF, 32'h00000010, 0, 64'h0000000F_0FFFFFFF);
    issue(32'd1000, 32'd3, 0, 64'd0, 0, 0);
    repeat (11) @(negedge clk);
    chk("pre_annul_stall", {63'd0, stallreq}, 64'd1);
    annul = 1;
    @(negedge clk);
    chk("annul_ready", {63'd0, ready}, 64'd0);
    chk("annul_stall", {63'd0, stallreq}, 64'd0);
    chk("annul_result", result, 64'h0000000F_0FFFFFFF);
    opdata1 = 32'd9; opdata2 = 32'd3; signed_div = 0; annul = 0;
    push_exp(64'h00000000_00000003, 33);
    finish_div(st);
    issue(32'd1000, 32'd7, 0, 64'd0, 0, 0);
    repeat (5) @(negedge clk);
    #2 start = 0; rst = 0;
    #1;
    chk("arst_ready", {63'd0, ready}, 64'd0);
    chk("arst_result", result, 64'd0);
    chk("arst_stall", {63'd0, stallreq}, 64'd0);
    @(negedge clk) rst = 1;
    issue(32'd50, 32'd5, 0, 64'h00000000_0000000A, 33, 1);
    finish_div(st);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width in bits; only 32 is supported.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  meaning divide request from EX; held high until ready is seen.
REQ-005 SHALL have port signed_div  input  1  meaning 1 = signed (DIV), 0 = unsigned (DIVU).
REQ-006 SHALL have port opdata1  input  32  meaning the dividend.
REQ-007 SHALL have port opdata2  input  32  meaning the divisor.
REQ-008 SHALL have port annul  input  1  meaning cancel the in-flight divide (pipeline flush).
REQ-009 SHALL have port result  output  64  meaning {remainder[31:0], quotient[31:0]}, HI = remainder, LO = quotient.
REQ-010 SHALL have port ready  output  1  meaning result valid.
REQ-011 SHALL have port stallreq  output  1  meaning request to freeze IF/ID/EX while the divide is busy.

Function
REQ-012 SHALL implement an FSM with states IDLE, BYZERO, ON and END.
REQ-013 SHALL take IDLE->BYZERO on an edge with start=1, annul=0 and opdata2=0.
REQ-014 SHALL take IDLE->ON on an edge with start=1, annul=0 and opdata2!=0, and SHALL latch the operands and signed_div on that edge.
REQ-015 SHALL, in signed mode, latch |opdata1| and |opdata2| as two's-complement magnitudes, and record sign_q = op1[31]^op2[31] and sign_r = op1[31].
REQ-016 SHALL, in ON, perform one restoring shift-subtract iteration per cycle on a 65-bit partial remainder, with a 6-bit counter counting 0..31.
REQ-017 SHALL, on the 32nd ON edge (counter=31), move to END, with the ready cycle exactly 33 edges after the accepting edge.
REQ-018 SHALL, on entering END, negate the quotient if sign_q and negate the remainder if sign_r, in signed mode only.
REQ-019 SHALL take BYZERO->END in one edge with result = 64'h0, making the ready cycle 2 edges after acceptance.
REQ-020 SHALL, in END, assert ready=1 and hold result stable.
REQ-021 SHALL take END->IDLE on an edge with start=0, and SHALL remain in END while start=1.
REQ-022 SHALL drive ready=0 in IDLE, BYZERO and ON.
REQ-023 SHALL, in IDLE, hold result at its last value, at 0 after reset.
REQ-024 SHALL drive stallreq = (state==BYZERO || state==ON || (state==IDLE && start && !annul)), combinationally.
REQ-025 SHALL drive stallreq=0 in END so the pipeline advances in the ready cycle.
REQ-026 SHALL, with annul=1 in any state, move to IDLE on the next edge, leave ready=0 and leave result unchanged.
REQ-027 SHALL give annul priority over start and over counter completion in the same cycle.
REQ-028 SHALL ignore operand changes in ON/BYZERO/END, using the latched copies only.
REQ-029 SHALL handle 0x80000000 / 0xFFFFFFFF signed with quotient 0x80000000 and remainder 0, with no trap.
REQ-030 SHALL use unsigned arithmetic internally, with all negations modulo 2^32.

Reset
REQ-031 SHALL, when rst=0, immediately and without waiting for clk, set state=IDLE, counter=0, the partial remainder to 0 and result=0.
REQ-032 SHALL, when rst=0, force ready=0 and the registered part of stallreq to 0.
REQ-033 SHALL, on rst=0 mid-operation, abandon the divide with no ready pulse.
REQ-034 SHALL, after rst returns to 1, accept a new start on the first edge.

Verification
REQ-035 SHALL cover: unsigned 100/7, start held -> ready 33 edges later, result=64'h00000002_0000000E; stallreq=1 for 33 cycles.
REQ-036 SHALL cover: signed -7/2 (0xFFFFFFF9, 0x00000002) -> result=64'hFFFFFFFF_FFFFFFFD.
REQ-037 SHALL cover: signed 0x80000000/0xFFFFFFFF -> result=64'h00000000_80000000; unsigned 0xFFFFFFFF/0x10 -> 64'h0000000F_0FFFFFFF.
REQ-038 SHALL cover: opdata2=0 -> ready on edge 2 with result=0; start dropped -> IDLE next edge, ready=0.
REQ-039 SHALL cover: annul at ON counter=10 -> IDLE next edge, no ready; immediate new start 9/3 -> result=64'h00000000_00000003.
REQ-040 SHALL cover: rst=0 mid-ON between edges -> ready=0, result=0 asynchronously; after release 50/5 -> quotient 10, remainder 0.
